// File: rtl/jtframe_romslot_arb.sv
// Four-slot round-robin read arbiter in front of a single-port SDRAM controller.
// One transaction at a time: grant -> request/ack -> data -> one-cycle gap.
module jtframe_romslot_arb #(
  parameter int          SLOT_AW = 22,
  parameter logic [21:0] OFF0    = 22'd0,
  parameter logic [21:0] OFF1    = 22'd0,
  parameter logic [21:0] OFF2    = 22'd0,
  parameter logic [21:0] OFF3    = 22'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               downloading,
  input  logic [3:0]         slot_req,
  input  logic [SLOT_AW-1:0] slot_addr0,
  input  logic [SLOT_AW-1:0] slot_addr1,
  input  logic [SLOT_AW-1:0] slot_addr2,
  input  logic [SLOT_AW-1:0] slot_addr3,
  output logic [3:0]         slot_ok,
  output logic [31:0]        slot_dout,
  output logic               sdram_req,
  output logic [21:0]        sdram_addr,
  input  logic               sdram_ack,
  input  logic               data_rdy,
  input  logic [31:0]        data_read,
  output logic [1:0]         state_dbg
);

  // Handshake: sdram_req is a level held with a stable sdram_addr until the
  // cycle sdram_ack is sampled high; data_rdy only counts while a read is owed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int SUM_W = (SLOT_AW > 22) ? SLOT_AW : 22;

  state_t       state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [1:0]   last_q, last_d;
  logic         sdram_req_q, sdram_req_d;
  logic [21:0]  sdram_addr_q, sdram_addr_d;
  logic [3:0]   slot_ok_q, slot_ok_d;
  logic [31:0]  slot_dout_q, slot_dout_d;

  logic               pick_vld;
  logic [1:0]         pick;
  logic [1:0]         cand;
  logic [SLOT_AW-1:0] sel_addr;
  logic [21:0]        sel_off;
  logic [SUM_W-1:0]   sum_w;

  // Search starts just after the last served slot so every requester gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick     = 2'd0;
    cand     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = last_q + 2'(i + 1);
      if (!pick_vld && slot_req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    sel_addr = slot_addr0;
    sel_off  = OFF0;
    case (pick)
      2'd0: begin sel_addr = slot_addr0; sel_off = OFF0; end
      2'd1: begin sel_addr = slot_addr1; sel_off = OFF1; end
      2'd2: begin sel_addr = slot_addr2; sel_off = OFF2; end
      default: begin sel_addr = slot_addr3; sel_off = OFF3; end
    endcase
    sum_w = SUM_W'(sel_addr) + SUM_W'(sel_off);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    slot_ok_d    = 4'b0000;
    slot_dout_d  = slot_dout_q;
    case (state_q)
      ST_IDLE: begin
        if (!downloading && pick_vld) begin
          idx_d        = pick;
          sdram_addr_d = sum_w[21:0];
          sdram_req_d  = 1'b1;
          state_d      = ST_ACK;
        end
      end
      ST_ACK: begin
        if (sdram_ack) begin
          sdram_req_d = 1'b0;
          state_d     = ST_DATA;
          // Data may arrive together with the ack; complete in one step.
          if (data_rdy) begin
            slot_dout_d = data_read;
            slot_ok_d   = 4'b0001 << idx_q;
            last_d      = idx_q;
            state_d     = ST_GAP;
          end
        end
      end
      ST_DATA: begin
        if (data_rdy) begin
          slot_dout_d = data_read;
          slot_ok_d   = 4'b0001 << idx_q;
          last_d      = idx_q;
          state_d     = ST_GAP;
        end
      end
      default: begin
        // Lets the served slot drop its request before it is sampled again.
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      last_q       <= 2'd3;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= 22'd0;
      slot_ok_q    <= 4'b0000;
      slot_dout_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      slot_ok_q    <= slot_ok_d;
      slot_dout_q  <= slot_dout_d;
    end
  end

  assign slot_ok    = slot_ok_q;
  assign slot_dout  = slot_dout_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_jtframe_romslot_arb.sv
// Bench for jtframe_romslot_arb: vector table, round-robin, download blocking,
// same-cycle ack/data, address wrap and mid-transaction reset.
module tb_jtframe_romslot_arb;

  localparam logic [21:0] OFF0 = 22'h000010;
  localparam logic [21:0] OFF1 = 22'h008000;
  localparam logic [21:0] OFF2 = 22'h200000;
  localparam logic [21:0] OFF3 = 22'h3FFFFF;

  logic        clk;
  logic        rst_n;
  logic        downloading;
  logic [3:0]  slot_req;
  logic [21:0] slot_addr [4];
  logic [3:0]  slot_ok;
  logic [31:0] slot_dout;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] data_read;
  logic [1:0]  state_dbg;

  int checks;
  int errors;

  logic [35:0] exp_q[$];   // {slot_ok, slot_dout} per expected strobe
  logic [21:0] addr_q[$];  // sdram_addr per expected request

  typedef struct {
    int          slot;
    logic [21:0] addr;
    int          ack_dly;
    int          rdy_dly;
    bit          same;
    logic [31:0] data;
    logic [21:0] exp_addr;
  } vec_t;

  vec_t vecs[5];
  logic [21:0] offs[4];

  jtframe_romslot_arb #(
    .SLOT_AW(22), .OFF0(OFF0), .OFF1(OFF1), .OFF2(OFF2), .OFF3(OFF3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .slot_req(slot_req),
    .slot_addr0(slot_addr[0]), .slot_addr1(slot_addr[1]),
    .slot_addr2(slot_addr[2]), .slot_addr3(slot_addr[3]),
    .slot_ok(slot_ok), .slot_dout(slot_dout),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int slot);
    logic [3:0] v;
    v = 4'b0001 << slot;
    return v;
  endfunction

  // driver: plays the SDRAM controller for one granted transaction
  task automatic serve(input int slot, input int ack_dly, input int rdy_dly, input bit same,
                       input logic [31:0] data, input logic [21:0] exp_addr, input bit scramble);
    int n;
    n = 0;
    while (sdram_req !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("req_seen", 64'(sdram_req), 64'(1'b1));
    if (scramble) slot_addr[slot] = ~slot_addr[slot];
    repeat (ack_dly) @(posedge clk);
    #1;
    check("addr_hold", 64'(sdram_addr), 64'(exp_addr));
    check("req_hold", 64'(sdram_req), 64'(1'b1));
    sdram_ack = 1'b1;
    if (same) begin
      data_rdy  = 1'b1;
      data_read = data;
    end
    @(posedge clk); #1;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    check("req_clear", 64'(sdram_req), 64'(1'b0));
    if (!same) begin
      check("data_state", 64'(state_dbg), 64'(2'd2));
      repeat (rdy_dly) @(posedge clk);
      #1;
      data_rdy  = 1'b1;
      data_read = data;
      @(posedge clk); #1;
      data_rdy  = 1'b0;
    end
    check("ok_strobe", 64'(slot_ok), 64'(onehot(slot)));
    check("gap_state", 64'(state_dbg), 64'(2'd3));
    slot_req[slot] = 1'b0;
  endtask

  task automatic expect_txn(input int slot, input logic [21:0] a, input logic [31:0] d);
    addr_q.push_back(a);
    exp_q.push_back({onehot(slot), d});
  endtask

  initial begin
    int n;
    int s;
    logic [21:0] ra;
    logic [22:0] rsum;
    logic [31:0] rd;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    downloading = 1'b0;
    slot_req = 4'b0000;
    for (int i = 0; i < 4; i++) slot_addr[i] = 22'd0;
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    data_read = 32'd0;
    offs[0] = OFF0; offs[1] = OFF1; offs[2] = OFF2; offs[3] = OFF3;

    vecs[0] = '{1, 22'h000100, 2, 3, 1'b0, 32'hDEADBEEF, 22'h008100};
    vecs[1] = '{0, 22'h3FFFF0, 0, 0, 1'b0, 32'hA5A50F0F, 22'h000000};
    vecs[2] = '{2, 22'h1FFFFF, 1, 1, 1'b0, 32'h00000000, 22'h3FFFFF};
    vecs[3] = '{2, 22'h000123, 3, 2, 1'b0, 32'hFFFFFFFF, 22'h200123};
    vecs[4] = '{3, 22'h000002, 1, 0, 1'b1, 32'h12345678, 22'h000001};

    // scoreboard monitor, sampled on the falling edge
    fork
      begin
        logic prev_req;
        logic [35:0] e;
        logic [21:0] ea;
        prev_req = 1'b0;
        forever begin
          @(negedge clk);
          if (slot_ok != 4'b0000) begin
            if (exp_q.size() == 0) begin
              check("unexpected_ok", 64'(slot_ok), 64'(4'b0000));
            end else begin
              e = exp_q.pop_front();
              check("sb_ok_dout", 64'({slot_ok, slot_dout}), 64'(e));
            end
          end
          if (sdram_req && !prev_req) begin
            if (addr_q.size() == 0) begin
              check("unexpected_req", 64'(sdram_req), 64'(1'b0));
            end else begin
              ea = addr_q.pop_front();
              check("sb_addr", 64'(sdram_addr), 64'(ea));
            end
          end
          prev_req = sdram_req;
        end
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 64'(sdram_req), 64'(1'b0));
    check("rst_addr", 64'(sdram_addr), 64'(22'd0));
    check("rst_ok", 64'(slot_ok), 64'(4'b0000));
    check("rst_dout", 64'(slot_dout), 64'(32'd0));
    check("rst_state", 64'(state_dbg), 64'(2'd0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // table-driven single requests
    for (int v = 0; v < 5; v++) begin
      slot_addr[vecs[v].slot] = vecs[v].addr;
      slot_req[vecs[v].slot]  = 1'b1;
      expect_txn(vecs[v].slot, vecs[v].exp_addr, vecs[v].data);
      @(posedge clk); #1;
      check("grant_lat", 64'(sdram_req), 64'(1'b1));
      serve(vecs[v].slot, vecs[v].ack_dly, vecs[v].rdy_dly, vecs[v].same,
            vecs[v].data, vecs[v].exp_addr, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("dout_hold", 64'(slot_dout), 64'(vecs[v].data));
      check("ok_idle", 64'(slot_ok), 64'(4'b0000));
    end

    // round robin with all four requesting; last served is slot 3
    for (int i = 0; i < 4; i++) begin
      slot_addr[i] = 22'h000040 + 22'(i);
      expect_txn(i, 22'h000040 + 22'(i) + offs[i], 32'h11110000 + 32'(i));
    end
    slot_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      serve(i, 1, 1, 1'b0, 32'h11110000 + 32'(i), 22'h000040 + 22'(i) + offs[i], 1'b0);
      if (i < 3) begin
        n = 0;
        while (sdram_req !== 1'b1 && n < 10) begin
          @(posedge clk); #1; n++;
          if (n == 1) check("rr_ok_pulse", 64'(slot_ok), 64'(4'b0000));
        end
        check("rr_gap_cycles", 64'(n), 64'(2));
      end
    end
    repeat (3) @(posedge clk);
    #1;

    // random single requests
    for (int k = 0; k < 6; k++) begin
      s  = $urandom_range(0, 3);
      ra = 22'($urandom_range(0, 32'h3FFFFF));
      rd = $urandom;
      rsum = {1'b0, ra} + {1'b0, offs[s]};
      slot_addr[s] = ra;
      slot_req[s]  = 1'b1;
      expect_txn(s, rsum[21:0], rd);
      serve(s, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            rd, rsum[21:0], 1'b1);
      repeat (2) @(posedge clk);
      #1;
    end

    // download raised during ACK of slot 2
    slot_addr[2] = 22'h000005;
    slot_req[2]  = 1'b1;
    expect_txn(2, 22'h200005, 32'h0BADF00D);
    @(posedge clk); #1;
    check("dl_grant", 64'(sdram_req), 64'(1'b1));
    downloading = 1'b1;
    slot_addr[0] = 22'h000007;
    slot_req[0]  = 1'b1;
    serve(2, 2, 1, 1'b0, 32'h0BADF00D, 22'h200005, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("dl_block_req", 64'(sdram_req), 64'(1'b0));
    check("dl_block_state", 64'(state_dbg), 64'(2'd0));
    expect_txn(0, 22'h000017, 32'hCAFEF00D);
    downloading = 1'b0;
    serve(0, 0, 0, 1'b0, 32'hCAFEF00D, 22'h000017, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // reset while in DATA of slot 2; last served was slot 0
    slot_addr[2] = 22'h000040;
    slot_req[2]  = 1'b1;
    addr_q.push_back(22'h200040);
    n = 0;
    while (sdram_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("rst_txn_req", 64'(sdram_req), 64'(1'b1));
    sdram_ack = 1'b1;
    @(posedge clk); #1;
    sdram_ack = 1'b0;
    check("rst_txn_data", 64'(state_dbg), 64'(2'd2));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", 64'(slot_dout), 64'(32'd0));
    check("mid_rst_ok", 64'(slot_ok), 64'(4'b0000));
    check("mid_rst_req", 64'(sdram_req), 64'(1'b0));
    check("mid_rst_addr", 64'(sdram_addr), 64'(22'd0));
    check("mid_rst_state", 64'(state_dbg), 64'(2'd0));
    slot_req = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    data_rdy  = 1'b1;
    data_read = 32'h55AA55AA;
    @(posedge clk); #1;
    data_rdy = 1'b0;
    check("late_rdy_ok", 64'(slot_ok), 64'(4'b0000));
    check("late_rdy_dout", 64'(slot_dout), 64'(32'd0));
    slot_addr[0] = 22'h000001;
    slot_addr[2] = 22'h000002;
    expect_txn(0, 22'h000011, 32'h00C0FFEE);
    expect_txn(2, 22'h200002, 32'hBEEF0002);
    slot_req = 4'b0101;
    serve(0, 1, 0, 1'b0, 32'h00C0FFEE, 22'h000011, 1'b0);
    serve(2, 0, 1, 1'b1, 32'hBEEF0002, 22'h200002, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    check("addr_q_empty", 64'(addr_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtframe_romslot_arb.md
JTFRAME_ROMSLOT_ARB -- requirements
Module: jtframe_romslot_arb

Interface
Parameters, one per line (name, default, meaning):
REQ-001 SHALL have parameter SLOT_AW, default 22, giving the slot address width in SDRAM words.
REQ-002 SHALL have parameters OFF0, OFF1, OFF2 and OFF3, each 22 bits, default 0, giving the SDRAM base word offset added to each slot address.

Ports, one per line (name, direction, width, meaning). Clock and reset:
REQ-003 SHALL have clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have rst_n, input, 1: reset, asynchronous and active-low.

Control and slot side:
REQ-005 SHALL have downloading, input, 1: ROM download in progress; new arbitration is blocked while it is high.
REQ-006 SHALL have slot_req, input, 4: per-slot level request, held until that slot's slot_ok.
REQ-007 SHALL have slot_addr0 to slot_addr3, input, SLOT_AW each: per-slot word address, valid while the matching slot_req is high.
REQ-008 SHALL have slot_ok, output, 4: per-slot one-cycle data-valid strobe.
REQ-009 SHALL have slot_dout, output, 32: shared read data, valid when any slot_ok bit is high.

SDRAM side:
REQ-010 SHALL have sdram_req, output, 1: read request.
REQ-011 SHALL have sdram_addr, output, 22: read word address.
REQ-012 SHALL have sdram_ack, input, 1: controller accepted the request.
REQ-013 SHALL have data_rdy, input, 1: data_read is valid this cycle.
REQ-014 SHALL have data_read, input, 32: SDRAM read data.

Function
REQ-015 SHALL implement a four-state FSM: IDLE, ACK, DATA, GAP.
REQ-016 IDLE: when downloading=0 and slot_req is not 0, SHALL choose a slot by round-robin, starting at last_served+1 modulo 4.
REQ-017 On a grant in IDLE, SHALL latch the slot index and set sdram_addr = {zero-extended slot address} + OFFn, truncated to 22 bits (wrap-around is allowed and not flagged).
REQ-018 On the same grant, SHALL assert sdram_req and move to ACK; the grant decision is registered (1 cycle from request to sdram_req).
REQ-019 ACK: SHALL hold sdram_req and sdram_addr stable until sdram_ack=1, then clear sdram_req and move to DATA.
REQ-020 ACK: if data_rdy is high in the same cycle as sdram_ack, SHALL treat it as ACK followed immediately by DATA completion (state goes straight to GAP).
REQ-021 DATA: on data_rdy=1, SHALL register data_read into slot_dout and pulse slot_ok[idx] for exactly one cycle.
REQ-022 DATA: on the same data_rdy, SHALL set last_served=idx and move to GAP.
REQ-023 DATA: data_rdy seen in IDLE or GAP SHALL be ignored, with no slot_ok pulse.
REQ-024 GAP: SHALL stay exactly one cycle, then return to IDLE, so the served slot can drop slot_req before arbitration re-samples it.
REQ-025 slot_ok SHALL be one-hot or zero at all times.
REQ-026 slot_dout SHALL hold its last value between strobes.
REQ-027 A slot_req that drops before it is granted SHALL be dropped silently.
REQ-028 A change in a slot address after grant SHALL not affect the transaction in flight.
REQ-029 If downloading rises during ACK or DATA, the transaction in flight SHALL complete normally; the FSM then stays in IDLE while downloading=1.
REQ-030 Slot service latency from grant SHALL be 1 cycle to sdram_req, plus controller latency, plus 1 cycle to slot_ok.

Reset
REQ-031 When rst_n=0, SHALL asynchronously force state=IDLE, sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0, idx=0 and last_served=3, so that slot 0 has first priority.
REQ-032 Reset mid-transaction SHALL abandon it with no slot_ok pulse; a data_rdy arriving after reset release SHALL be ignored under REQ-023.

Verification
REQ-033 Single request: slot_req=4'b0010, slot_addr1=0x100, OFF1=0x8000, ack after 2 cycles, data_rdy with 0xDEADBEEF after 3 more cycles -> sdram_addr=0x8100, slot_ok=4'b0010 for 1 cycle, slot_dout=0xDEADBEEF.
REQ-034 Round-robin: slot_req=4'b1111 held, each slot dropping its request on its slot_ok -> grant order 0,1,2,3 with exactly one GAP cycle between transactions.
REQ-035 Download blocking: downloading=1 asserted during ACK of slot 2 -> slot 2 completes with slot_ok=4'b0100; no further sdram_req until downloading=0.
REQ-036 Wrap-around and same-cycle events: OFF3=0x3FFFFF, slot_addr3=2 -> sdram_addr=0x000001; with sdram_ack and data_rdy in the same cycle -> slot_ok[3] pulses on the next cycle.
REQ-037 Reset mid-operation: rst_n low for 1 cycle in DATA -> all outputs 0 immediately; a later data_rdy -> no slot_ok; next grant goes to slot 0 first.
